// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the 5-stage MIPS pipeline control blocks.
package mips_pipe_pkg;

    // Register-file index width and the hardwired zero register.
    localparam int unsigned REG_W    = 5;
    localparam logic [4:0]  REG_ZERO = 5'd0;

    // Hazard controller state encoding.
    localparam int unsigned STATE_W = 2;
    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_RUN      = 2'd0;
    localparam state_t ST_MEM_WAIT = 2'd1;
    localparam state_t ST_ERR      = 2'd2;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Load-use compare: the ID instruction needs a register that the load in EX
// has not produced yet. Kept standalone so a forwarding unit can reuse it.
module hazard_detect
    import mips_pipe_pkg::*;
(
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             idex_memread,
    input  logic [REG_W-1:0] idex_rt,
    output logic             load_use_c
);

    // A load to $zero never creates a dependency.
    always_comb begin
        load_use_c = idex_memread && (idex_rt != REG_ZERO) &&
                     ((idex_rt == id_rs) || (id_uses_rt && (idex_rt == id_rt)));
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage MIPS pipeline: load-use
// stalls, branch/jump squashes, data-memory wait freeze and a hung-memory
// watchdog. Control outputs are combinational from state and inputs.
module pipeline_hazard_ctrl
    import mips_pipe_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             id_jump,
    input  logic             idex_memread,
    input  logic [4:0]       idex_rt,
    input  logic             ex_branch_taken,
    input  logic             exmem_memread,
    input  logic             exmem_memwrite,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             memwb_flush,
    output logic             dmem_req,
    output logic             timeout_err,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int unsigned WAIT_W = 8;

    state_t              state;
    state_t              next_state;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [WAIT_W-1:0]   next_wait;
    logic                mem_op;
    logic                load_use_c;
    logic                freeze;
    logic                resolve;
    logic                lu_fire;
    logic                stall_inc;

    hazard_detect u_hazard_detect (
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rt   (id_uses_rt),
        .idex_memread (idex_memread),
        .idex_rt      (idex_rt),
        .load_use_c   (load_use_c)
    );

    assign mem_op = exmem_memread | exmem_memwrite;

    // Next-state and control outputs; freeze dominates, then branch, jump, load-use.
    always_comb begin
        next_state  = state;
        next_wait   = wait_cnt;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_en     = 1'b1;
        idex_flush  = 1'b0;
        exmem_en    = 1'b1;
        memwb_flush = 1'b0;
        dmem_req    = 1'b0;
        freeze      = 1'b0;
        resolve     = 1'b0;
        lu_fire     = 1'b0;

        case (state)
            ST_RUN: begin
                dmem_req  = mem_op;
                next_wait = '0;
                if (mem_op && !dmem_ready) begin
                    next_state = ST_MEM_WAIT;
                    freeze     = 1'b1;
                end else begin
                    resolve = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                dmem_req = 1'b1;
                if (dmem_ready) begin
                    next_state = ST_RUN;
                    next_wait  = '0;
                    resolve    = 1'b1;
                end else begin
                    freeze = 1'b1;
                    if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
                        next_state = ST_ERR;
                    end else begin
                        next_wait = wait_cnt + WAIT_W'(1);
                    end
                end
            end
            ST_ERR: begin
                pc_en       = 1'b0;
                ifid_en     = 1'b0;
                idex_en     = 1'b0;
                exmem_en    = 1'b0;
                memwb_flush = 1'b1;
            end
            default: begin
                next_state = ST_RUN;
            end
        endcase

        if (freeze) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_flush = 1'b1;
        end else if (resolve) begin
            if (ex_branch_taken) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (id_jump) begin
                ifid_flush = 1'b1;
            end else if (load_use_c) begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
                lu_fire    = 1'b1;
            end
        end

        // While reset is held the pipeline free-runs with no request issued.
        if (!reset) begin
            pc_en       = 1'b1;
            ifid_en     = 1'b1;
            ifid_flush  = 1'b0;
            idex_en     = 1'b1;
            idex_flush  = 1'b0;
            exmem_en    = 1'b1;
            memwb_flush = 1'b0;
            dmem_req    = 1'b0;
            lu_fire     = 1'b0;
        end
    end

    assign stall_inc = lu_fire | (state != ST_RUN);

    // State and wait counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
        end else begin
            state    <= next_state;
            wait_cnt <= next_wait;
        end
    end

    // Saturating stall counter and sticky watchdog flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cycles <= '0;
            timeout_err  <= 1'b0;
        end else begin
            if (stall_inc && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if (next_state == ST_ERR) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios followed by
// random stimulus, all compared every cycle against a behavioural model.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned TO = 4;
    localparam int unsigned CW = 5;
    localparam int SAT = (1 << CW) - 1;

    localparam int M_RUN  = 0;
    localparam int M_WAIT = 1;
    localparam int M_ERR  = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [4:0]    id_rs, id_rt, idex_rt;
    logic          id_uses_rt, id_jump, idex_memread, ex_branch_taken;
    logic          exmem_memread, exmem_memwrite, dmem_ready;
    logic          pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
    logic          exmem_en, memwb_flush, dmem_req, timeout_err;
    logic [CW-1:0] stall_cycles;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state
    int m_mode, m_wait, m_stall;
    bit m_err;
    // Model expectations for the current cycle
    bit e_pc, e_ifen, e_iffl, e_idexen, e_idexfl, e_exmemen, e_wbfl, e_req, e_lu;
    // DUT values sampled in the last checked cycle
    logic s_pc_en, s_ifid_en, s_ifid_flush, s_idex_flush, s_dmem_req, s_memwb_flush;

    pipeline_hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk             (clk),
        .reset           (reset),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rt      (id_uses_rt),
        .id_jump         (id_jump),
        .idex_memread    (idex_memread),
        .idex_rt         (idex_rt),
        .ex_branch_taken (ex_branch_taken),
        .exmem_memread   (exmem_memread),
        .exmem_memwrite  (exmem_memwrite),
        .dmem_ready      (dmem_ready),
        .pc_en           (pc_en),
        .ifid_en         (ifid_en),
        .ifid_flush      (ifid_flush),
        .idex_en         (idex_en),
        .idex_flush      (idex_flush),
        .exmem_en        (exmem_en),
        .memwb_flush     (memwb_flush),
        .dmem_req        (dmem_req),
        .timeout_err     (timeout_err),
        .stall_cycles    (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected control outputs from the rules, given model state and current inputs.
    task automatic model_eval();
        bit mem_op, hazard;
        e_pc = 1; e_ifen = 1; e_iffl = 0; e_idexen = 1; e_idexfl = 0;
        e_exmemen = 1; e_wbfl = 0; e_req = 0; e_lu = 0;
        if (reset) begin
            mem_op = exmem_memread || exmem_memwrite;
            hazard = idex_memread && (idex_rt != 0) &&
                     ((idex_rt == id_rs) || (id_uses_rt && (idex_rt == id_rt)));
            if (m_mode == M_ERR) begin
                e_pc = 0; e_ifen = 0; e_idexen = 0; e_exmemen = 0; e_wbfl = 1;
            end else begin
                e_req = (m_mode == M_WAIT) ? 1'b1 : mem_op;
                if (!dmem_ready && (m_mode == M_WAIT || mem_op)) begin
                    e_pc = 0; e_ifen = 0; e_idexen = 0; e_exmemen = 0; e_wbfl = 1;
                end else if (ex_branch_taken) begin
                    e_iffl = 1; e_idexfl = 1;
                end else if (id_jump) begin
                    e_iffl = 1;
                end else if (hazard) begin
                    e_pc = 0; e_ifen = 0; e_idexfl = 1; e_lu = 1;
                end
            end
        end
    endtask

    // Advance the model across one rising edge.
    task automatic model_tick();
        if (!reset) begin
            m_mode = M_RUN; m_wait = 0; m_stall = 0; m_err = 0;
        end else begin
            if ((m_mode != M_RUN || e_lu) && m_stall < SAT) m_stall++;
            case (m_mode)
                M_RUN: if ((exmem_memread || exmem_memwrite) && !dmem_ready) begin
                    m_mode = M_WAIT; m_wait = 0;
                end
                M_WAIT: if (dmem_ready) begin
                    m_mode = M_RUN; m_wait = 0;
                end else if (m_wait == TO - 1) begin
                    m_mode = M_ERR; m_err = 1;
                end else begin
                    m_wait++;
                end
                default: ;
            endcase
        end
    endtask

    // One clock cycle: compare at the falling edge, update model at the rising edge.
    task automatic step();
        @(negedge clk);
        model_eval();
        s_pc_en = pc_en; s_ifid_en = ifid_en; s_ifid_flush = ifid_flush;
        s_idex_flush = idex_flush; s_dmem_req = dmem_req; s_memwb_flush = memwb_flush;
        check("pc_en",        32'(pc_en),        32'(e_pc));
        check("ifid_en",      32'(ifid_en),      32'(e_ifen));
        check("ifid_flush",   32'(ifid_flush),   32'(e_iffl));
        check("idex_en",      32'(idex_en),      32'(e_idexen));
        check("idex_flush",   32'(idex_flush),   32'(e_idexfl));
        check("exmem_en",     32'(exmem_en),     32'(e_exmemen));
        check("memwb_flush",  32'(memwb_flush),  32'(e_wbfl));
        check("dmem_req",     32'(dmem_req),     32'(e_req));
        check("stall_cycles", 32'(stall_cycles), 32'(m_stall));
        check("timeout_err",  32'(timeout_err),  32'(m_err));
        @(posedge clk);
        model_tick();
        #1;
    endtask

    task automatic idle();
        id_rs = 0; id_rt = 0; idex_rt = 0; id_uses_rt = 0; id_jump = 0;
        idex_memread = 0; ex_branch_taken = 0; exmem_memread = 0;
        exmem_memwrite = 0; dmem_ready = 1;
    endtask

    initial begin
        reset = 0;
        idle();
        @(posedge clk);
        #1;
        m_mode = M_RUN; m_wait = 0; m_stall = 0; m_err = 0;

        // Reset values
        step();
        check("rst_pc_en", 32'(s_pc_en), 32'd1);
        check("rst_dmem_req", 32'(s_dmem_req), 32'd0);
        reset = 1;
        step();

        // Load-use stall, then a load to $zero which must not stall
        idex_memread = 1; idex_rt = 8; id_rs = 8;
        step();
        check("lu_pc_en", 32'(s_pc_en), 32'd0);
        check("lu_idex_flush", 32'(s_idex_flush), 32'd1);
        check("lu_stall_cnt", 32'(stall_cycles), 32'd1);
        idex_rt = 0; id_rs = 0;
        step();
        check("lu_zero_pc_en", 32'(s_pc_en), 32'd1);
        check("lu_zero_cnt", 32'(stall_cycles), 32'd1);

        // Branch overrides a simultaneous load-use
        idex_rt = 8; id_rs = 8; ex_branch_taken = 1;
        step();
        check("br_pc_en", 32'(s_pc_en), 32'd1);
        check("br_ifid_flush", 32'(s_ifid_flush), 32'd1);
        check("br_cnt", 32'(stall_cycles), 32'd1);

        // Memory access with three wait cycles
        idle();
        exmem_memread = 1; dmem_ready = 0;
        repeat (3) begin
            step();
            check("mw_wbflush", 32'(s_memwb_flush), 32'd1);
            check("mw_req", 32'(s_dmem_req), 32'd1);
        end
        dmem_ready = 1;
        step();
        check("mw_resume_en", 32'(s_ifid_en), 32'd1);
        check("mw_cnt", 32'(stall_cycles), 32'd4);
        idle();
        step();

        // Jump held across a memory stall is acted on at resume
        exmem_memwrite = 1; id_jump = 1; dmem_ready = 0;
        repeat (2) begin
            step();
            check("jmp_wait_noflush", 32'(s_ifid_flush), 32'd0);
        end
        dmem_ready = 1;
        step();
        check("jmp_resume_flush", 32'(s_ifid_flush), 32'd1);
        idle();
        step();

        // Reset in the middle of a memory wait
        exmem_memread = 1; dmem_ready = 0;
        repeat (2) step();
        reset = 0;
        step();
        check("rstw_req", 32'(s_dmem_req), 32'd0);
        check("rstw_cnt", 32'(stall_cycles), 32'd0);
        reset = 1;
        idle();
        step();
        check("rstw_en", 32'(s_pc_en), 32'd1);
        check("rstw_err", 32'(timeout_err), 32'd0);

        // Watchdog timeout, ERR is sticky, counter saturates
        exmem_memread = 1; dmem_ready = 0;
        repeat (1 + TO) step();
        check("to_err", 32'(timeout_err), 32'd1);
        dmem_ready = 1;
        repeat (40) begin
            step();
            check("err_req", 32'(s_dmem_req), 32'd0);
        end
        check("sat_cnt", 32'(stall_cycles), 32'(SAT));
        reset = 0;
        step();
        reset = 1;
        idle();
        step();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            id_rs           = 5'($urandom_range(0, 3));
            id_rt           = 5'($urandom_range(0, 3));
            idex_rt         = 5'($urandom_range(0, 3));
            id_uses_rt      = 1'($urandom_range(0, 1));
            idex_memread    = ($urandom_range(0, 2) == 0);
            id_jump         = ($urandom_range(0, 5) == 0);
            ex_branch_taken = ($urandom_range(0, 5) == 0);
            exmem_memread   = ($urandom_range(0, 3) == 0);
            exmem_memwrite  = ($urandom_range(0, 4) == 0);
            dmem_ready      = ($urandom_range(0, 3) != 0);
            reset           = (m_mode == M_ERR) ? ($urandom_range(0, 4) != 0)
                                                : ($urandom_range(0, 59) != 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
